// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding, default sizing
// and the timeout counter width helper.
package uart_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 1_000_000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Bits needed to hold limit-1 without wrapping; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    if (limit > 1) begin
      return $clog2(limit);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester byte streams plus the uart_tx start/busy handshake, bundled for the arbiter.
interface uart_tx_arb_if
  import uart_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) ();

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [NREQ-1:0]   grant;
  logic              timeout;

  modport master (
    output req_valid, req_last, req_data, tx_busy,
    input  req_ready, tx_start, tx_data, grant, timeout
  );

  modport slave (
    input  req_valid, req_last, req_data, tx_busy,
    output req_ready, tx_start, tx_data, grant, timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester after last_owner (wrapping) wins.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [NREQ-1:0]  winner_oh,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any_req
);

  logic [IDX_W:0] pos_s;
  logic           found_s;

  // Walk NREQ positions starting one past the previous owner; keep the first hit.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found_s    = 1'b0;
    pos_s      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos_s = {1'b0, last_owner} + (IDX_W + 1)'(k);
      if (pos_s >= (IDX_W + 1)'(NREQ)) begin
        pos_s = pos_s - (IDX_W + 1)'(NREQ);
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && req[pos_s[IDX_W-1:0]]) begin
        found_s                       = 1'b1;
        winner_idx                    = pos_s[IDX_W-1:0];
        winner_oh[pos_s[IDX_W-1:0]] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx among NREQ byte streams; a multi-byte message keeps the
// grant until its last byte or until the owner stays idle for TIMEOUT cycles.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus
);

  localparam int                IDX_W    = $clog2(NREQ);
  localparam int                CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_r;
  logic [IDX_W-1:0] last_owner_r;
  logic             lock_r;
  logic [CNT_W-1:0] cnt_r;
  logic             tx_start_r;
  logic [7:0]       tx_data_r;
  logic [NREQ-1:0]  grant_r;
  logic             timeout_r;

  logic [NREQ-1:0]  win_oh_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             any_s;
  logic [NREQ-1:0]  ready_s;
  logic [IDX_W-1:0] xfer_idx_s;
  logic             xfer_s;
  logic [7:0]       xfer_byte_s;
  logic             xfer_last_s;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (bus.req_valid),
    .last_owner (last_owner_r),
    .winner_oh  (win_oh_s),
    .winner_idx (win_idx_s),
    .any_req    (any_s)
  );

  // Accept offer: IDLE offers the round-robin winner, HOLD offers only the current owner.
  always_comb begin
    ready_s    = '0;
    xfer_idx_s = last_owner_r;
    if (rst || bus.tx_busy) begin
      ready_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            ready_s    = win_oh_s;
            xfer_idx_s = win_idx_s;
          end else begin
            ready_s = '0;
          end
        end
        ST_HOLD: begin
          ready_s    = grant_r;
          xfer_idx_s = last_owner_r;
        end
        default: ready_s = '0;
      endcase
    end
  end

  assign xfer_s      = |(ready_s & bus.req_valid);
  assign xfer_byte_s = bus.req_data[{xfer_idx_s, 3'b000} +: 8];
  assign xfer_last_s = bus.req_last[xfer_idx_s];

  // Arbitration FSM; a transfer (only possible in IDLE/HOLD) takes priority over timeout expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_owner_r <= IDX_W'(NREQ - 1);
      lock_r       <= 1'b0;
      cnt_r        <= '0;
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      grant_r      <= '0;
      timeout_r    <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      timeout_r  <= 1'b0;
      if (xfer_s) begin
        tx_start_r   <= 1'b1;
        tx_data_r    <= xfer_byte_s;
        grant_r      <= ready_s;
        last_owner_r <= xfer_idx_s;
        lock_r       <= ~xfer_last_s;
        state_r      <= ST_START;
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_IDLE;
          ST_START: state_r <= ST_BUSY;
          ST_BUSY: begin
            if (!bus.tx_busy) begin
              if (lock_r) begin
                state_r <= ST_HOLD;
                cnt_r   <= '0;
              end else begin
                state_r <= ST_IDLE;
                grant_r <= '0;
              end
            end else begin
              state_r <= ST_BUSY;
            end
          end
          ST_HOLD: begin
            if (cnt_r == CNT_LAST) begin
              state_r   <= ST_IDLE;
              grant_r   <= '0;
              lock_r    <= 1'b0;
              cnt_r     <= '0;
              timeout_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.tx_start  = tx_start_r;
  assign bus.tx_data   = tx_data_r;
  assign bus.grant     = grant_r;
  assign bus.timeout   = timeout_r;

endmodule
